// File: rtl/serial_tx_cnt_shift.sv
// serial_tx_cnt_shift: framed parallel-in/serial-out transmitter (start bit 1, then WIDTH data bits MSB first)
module serial_tx_cnt_shift #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] PI,
  output logic             so,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);
  typedef enum logic [1:0] {IDLE, SSTART, DATA, FIN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             so_q, so_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    so_d    = so_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (en) begin
      case (state_q)
        SSTART: begin
          so_d    = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
          cnt_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            so_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = FIN;
          end else begin
            so_d    = shreg_q[WIDTH-1];
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // IDLE and FIN both accept a word; FIN accepting gives the back-to-back single-gap case
          if (start) begin
            shreg_d = PI;
            so_d    = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            cnt_d   = '0;
            state_d = SSTART;
          end else begin
            so_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = IDLE;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign so      = so_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_cnt = cnt_q;
endmodule

// File: tb/tb_serial_tx_cnt_shift.sv
// tb_serial_tx_cnt_shift: scoreboard bench; expected {so,busy,done,bit_cnt} per cycle is queued and popped after each edge
module tb_serial_tx_cnt_shift;
  logic       clk, rst, en, start;
  logic [7:0] PI;
  logic       so, busy, done;
  logic [3:0] bit_cnt;
  logic [6:0] obs, e;
  logic [6:0] exp_q[$];
  int total = 0, bad = 0;
  serial_tx_cnt_shift #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .PI(PI),
    .so(so), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );
  assign obs = {so, busy, done, bit_cnt};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back({1'b1, 1'b1, 1'b0, 4'd0});
    for (int i = 0; i < 8; i++) exp_q.push_back({d[7-i], 1'b1, 1'b0, 4'(i)});
    exp_q.push_back({1'b0, 1'b0, 1'b1, 4'd0});
  endtask
  task automatic test_reset();
    rst = 1'b0; en = 1'b1; start = 1'b0; PI = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 7'd0) begin bad++; $display("FAIL reset_hold got %b want %b", obs, 7'd0); end
    rst = 1'b1;
    repeat (5) exp_q.push_back(7'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset_idle cyc%0d got %b want %b", i, obs, e); end
    end
  endtask
  task automatic test_en_start();
    en = 1'b0; start = 1'b1; PI = 8'h55;
    repeat (3) exp_q.push_back(7'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL en_start cyc%0d got %b want %b", i, obs, e); end
      if (i == 1) begin start = 1'b0; en = 1'b1; end
    end
  endtask
  task automatic test_single();
    PI = 8'hA5; start = 1'b1;
    push_frame(8'hA5);
    exp_q.push_back(7'd0);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL single cyc%0d got %b want %b", i, obs, e); end
      if (i == 0) start = 1'b0;
    end
  endtask
  task automatic test_back_to_back();
    PI = 8'hFF; start = 1'b1;
    push_frame(8'hFF);
    push_frame(8'h00);
    exp_q.push_back(7'd0);
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL back_to_back cyc%0d got %b want %b", i, obs, e); end
      if (i == 0) PI = 8'h00;
      if (i == 19) start = 1'b0;
    end
  endtask
  task automatic test_stall();
    PI = 8'h81; start = 1'b1;
    push_frame(8'h81);
    exp_q.push_back(7'd0);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall cyc%0d got %b want %b", i, obs, e); end
      if (i == 0) start = 1'b0;
      if (i == 4) begin en = 1'b0; repeat (3) exp_q.push_front(e); end
      if (i == 7) en = 1'b1;
    end
  endtask
  task automatic test_ignored_start();
    PI = 8'hC3; start = 1'b1;
    push_frame(8'hC3);
    repeat (3) exp_q.push_back(7'd0);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL ignored_start cyc%0d got %b want %b", i, obs, e); end
      if (i == 0) start = 1'b0;
      if (i == 5) begin start = 1'b1; PI = 8'h3C; end
      if (i == 6) start = 1'b0;
    end
  endtask
  task automatic test_async_reset();
    PI = 8'h5A; start = 1'b1;
    push_frame(8'h5A);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL async_pre cyc%0d got %b want %b", i, obs, e); end
      if (i == 0) start = 1'b0;
    end
    exp_q.delete();
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs !== 7'd0) begin bad++; $display("FAIL async_now got %b want %b", obs, 7'd0); end
    @(posedge clk); #1;
    total++;
    if (obs !== 7'd0) begin bad++; $display("FAIL async_hold got %b want %b", obs, 7'd0); end
    rst = 1'b1;
    repeat (3) exp_q.push_back(7'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL async_after cyc%0d got %b want %b", i, obs, e); end
    end
  endtask
  initial begin
    rst = 1'b0; en = 1'b1; start = 1'b0; PI = 8'h00;
    test_reset();
    test_en_start();
    test_single();
    test_back_to_back();
    test_stall();
    test_ignored_start();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
